// File: rtl/ov7670_config_sequencer.sv
// Walks an internal register table and issues one 3-phase SCCB write per entry,
// with idle gaps between writes and a long pause wherever a delay marker appears.
module ov7670_config_sequencer #(
    parameter logic [7:0]  DEVICE_ADDR    = 8'h42,
    parameter logic [15:0] GAP_CYCLES     = 16'd200,
    parameter logic [23:0] DELAY_CYCLES   = 24'd1000000,
    parameter logic [7:0]  ACCEPT_TIMEOUT = 8'd16
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_index,
    output logic       o_usher,
    output logic [7:0] o_address,
    output logic [7:0] o_subaddress,
    output logic [7:0] o_data,
    output logic [1:0] o_mode,
    input  logic       i_sccb_busy
);

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hF0F0;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        ISSUE,
        ACCEPT,
        WAIT,
        GAP,
        DELAY,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [15:0] rom_entry;
    logic [23:0] wait_cnt;
    logic [7:0]  accept_cnt;
    logic [8:0]  accept_next;

    assign o_address   = DEVICE_ADDR;
    assign o_mode      = 2'b00;
    assign accept_next = {1'b0, accept_cnt} + 9'd1;

    // Anything past the last real entry reads as an end marker.
    always_comb begin
        rom_entry = END_MARK;
        case (o_index)
            8'd0:    rom_entry = 16'h1280;
            8'd1:    rom_entry = 16'hF0F0;
            8'd2:    rom_entry = 16'h1204;
            8'd3:    rom_entry = 16'h1100;
            8'd4:    rom_entry = 16'h0C00;
            8'd5:    rom_entry = 16'h3E00;
            8'd6:    rom_entry = 16'h40D0;
            8'd7:    rom_entry = 16'hFFFF;
            default: rom_entry = END_MARK;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_usher      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_index      <= 8'd0;
            o_subaddress <= 8'd0;
            o_data       <= 8'd0;
            wait_cnt     <= 24'd0;
            accept_cnt   <= 8'd0;
        end else begin
            o_usher <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state   <= FETCH;
                        o_index <= 8'd0;
                        o_done  <= 1'b0;
                        o_error <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_entry == END_MARK) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else if (rom_entry == DELAY_MARK) begin
                        state    <= DELAY;
                        wait_cnt <= DELAY_CYCLES;
                    end else begin
                        o_subaddress <= rom_entry[15:8];
                        o_data       <= rom_entry[7:0];
                        o_usher      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    accept_cnt <= 8'd0;
                    state      <= ACCEPT;
                end
                // The master gets ACCEPT_TIMEOUT cycles to raise busy before we give up.
                ACCEPT: begin
                    if (i_sccb_busy) begin
                        state <= WAIT;
                    end else if (accept_next >= {1'b0, ACCEPT_TIMEOUT}) begin
                        state   <= ERROR;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        accept_cnt <= accept_next[7:0];
                    end
                end
                WAIT: begin
                    if (!i_sccb_busy) begin
                        wait_cnt <= {8'd0, GAP_CYCLES};
                        state    <= GAP;
                    end
                end
                GAP, DELAY: begin
                    if (wait_cnt == 24'd0) begin
                        o_index <= o_index + 8'd1;
                        state   <= FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - 24'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ov7670_config_sequencer.md
OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 8'h42, SCCB write ID driven on o_address.
REQ-002 SHALL have parameter GAP_CYCLES, default 16'd200, idle cycles between completed writes.
REQ-003 SHALL have parameter DELAY_CYCLES, default 24'd1000000, wait length for a delay-marker entry (10 ms at 100 MHz).
REQ-004 SHALL have parameter ACCEPT_TIMEOUT, default 8'd16, cycles allowed for SCCB busy to assert after a request.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, single-cycle request to run the configuration table.
REQ-008 SHALL have port o_busy, output, 1, high while the sequence runs.
REQ-009 SHALL have port o_done, output, 1, high after successful completion until next start or reset.
REQ-010 SHALL have port o_error, output, 1, high after an accept timeout until next start or reset.
REQ-011 SHALL have port o_index, output, 8, current table index.
REQ-012 SHALL have port o_usher, output, 1, single-cycle write request to the SCCB master.
REQ-013 SHALL have ports o_address, o_subaddress, o_data, outputs, 8 each; device ID, register address and register value to the SCCB master.
REQ-014 SHALL have port o_mode, output, 2, SCCB transaction mode; constant 2'b00 (3-phase write).
REQ-015 SHALL have port i_sccb_busy, input, 1, busy flag from the SCCB master.

Function
REQ-016 Table SHALL be internal combinational ROM of 16-bit {subaddr,data} entries indexed by o_index: 0:16'h1280, 1:16'hF0F0, 2:16'h1204, 3:16'h1100, 4:16'h0C00, 5:16'h3E00, 6:16'h40D0, 7:16'hFFFF.
REQ-017 Entry 16'hFFFF SHALL mean end-of-table; entry 16'hF0F0 SHALL mean delay; any index beyond the table SHALL read 16'hFFFF.
REQ-018 FSM states SHALL be IDLE, FETCH, ISSUE, ACCEPT, WAIT, GAP, DELAY, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR: i_start=1 -> FETCH next cycle, o_index<=0, o_done<=0, o_error<=0, o_busy<=1.
REQ-020 FETCH: end marker -> DONE; delay marker -> DELAY with counter loaded DELAY_CYCLES; otherwise latch entry to o_subaddress/o_data and -> ISSUE.
REQ-021 ISSUE: o_usher=1 for exactly one cycle -> ACCEPT; o_subaddress/o_data SHALL stay stable from ISSUE through WAIT.
REQ-022 ACCEPT: i_sccb_busy=1 -> WAIT; ACCEPT_TIMEOUT cycles without busy -> ERROR, o_index frozen at failing entry.
REQ-023 WAIT: i_sccb_busy=0 -> GAP with counter loaded GAP_CYCLES.
REQ-024 GAP and DELAY: count down to 0, then o_index<=o_index+1 -> FETCH.
REQ-025 Entering DONE SHALL set o_done=1 and o_busy=0 in the same cycle; entering ERROR SHALL set o_error=1 and o_busy=0.
REQ-026 i_start SHALL be ignored while o_busy=1.
REQ-027 o_address SHALL equal DEVICE_ADDR at all times; o_mode SHALL be 2'b00 at all times.
REQ-028 Busy asserted the cycle immediately after o_usher SHALL be accepted (minimum master latency 1).

Reset
REQ-029 i_rst_n=0 SHALL immediately force IDLE, o_usher=0, o_busy=0, o_done=0, o_error=0, o_index=0, o_subaddress=0, o_data=0, counters=0, regardless of state.
REQ-030 After reset release, no o_usher SHALL occur until i_start.

Verification
REQ-031 Reset asserted mid-run -> all outputs at REQ-029 values in same cycle, no usher for 50 cycles after release.
REQ-032 GAP=4, DELAY=100, SCCB model busy 2 cycles after usher for 50 cycles; start -> exactly 6 usher pulses carrying 12/80,12/04,11/00,0C/00,3E/00,40/D0; first-to-second pulse spacing >= 100 cycles; o_done=1 and o_busy=0 together.
REQ-033 SCCB model never asserts busy -> o_error=1 exactly 16 cycles after first ACCEPT cycle, o_index=0, single usher only.
REQ-034 i_start pulsed while busy -> ignored, sequence unchanged; i_start in DONE -> rerun from index 0, o_done cleared.
REQ-035 i_start in ERROR with working model -> o_error cleared, full run completes with o_done=1.
REQ-036 Model asserts busy 1 cycle after usher -> accepted, no timeout, sequence completes.
